// File: rtl/count_sequencer.sv
// Prescaled up/down counter sequencer with one-shot and continuous modes,
// pause/hold and abort. Outputs are registered.
module count_sequencer #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [3:0]            limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  continuous,
    input  logic                  down,
    output logic [3:0]            count,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                st;
    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] ps_q;
    logic [3:0]            lim_q;
    logic                  cont_q;
    logic                  down_q;

    logic [3:0] term_val;
    logic [3:0] start_val;
    logic       at_term;
    logic       tick;

    always_comb begin
        term_val  = down_q ? 4'd0 : lim_q;
        start_val = down_q ? lim_q : 4'd0;
        at_term   = (count == term_val);
        tick      = (pcnt == ps_q);
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            count  <= '0;
            pcnt   <= '0;
            ps_q   <= '0;
            lim_q  <= '0;
            cont_q <= 1'b0;
            down_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (stop) begin
                st   <= IDLE;
                busy <= 1'b0;
            end else if (start && (st == IDLE || st == DONE)) begin
                lim_q  <= limit;
                ps_q   <= prescale;
                cont_q <= continuous;
                down_q <= down;
                count  <= down ? limit : 4'd0;
                pcnt   <= '0;
                st     <= RUN;
                busy   <= 1'b1;
            end else if (st == RUN || st == HOLD) begin
                if (pause) begin
                    st <= HOLD;
                end else begin
                    // Leaving HOLD is itself an active cycle, so a pause of N
                    // cycles stretches the current value by exactly N.
                    st <= RUN;
                    if (tick) begin
                        pcnt <= '0;
                        if (!at_term) begin
                            count <= down_q ? count - 4'd1 : count + 4'd1;
                        end else if (cont_q) begin
                            count <= start_val;
                            wrap  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                            st   <= DONE;
                            busy <= 1'b0;
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: an elapsed-cycle arithmetic model
// predicts outputs per edge; a monitor compares them one cycle later.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, continuous, down;
  logic [3:0] limit;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       busy, done, wrap;
  logic [1:0] state;

  count_sequencer #(.PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .prescale(prescale), .continuous(continuous), .down(down),
    .count(count), .busy(busy), .done(done), .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [1:0] state;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_st = 0, m_count = 0, m_e = 0, m_lim = 0, m_ps = 0;
  bit m_cont = 0, m_down = 0, m_done = 0, m_wrap = 0;

  function automatic int value_at(int e);
    int idx;
    idx = (e / (m_ps + 1)) % (m_lim + 1);
    return m_down ? (m_lim - idx) : idx;
  endfunction

  function automatic void model_edge();
    int  idx;
    bit  term_tick;
    if (rst) begin
      m_st = 0; m_count = 0; m_e = 0; m_lim = 0; m_ps = 0;
      m_cont = 0; m_down = 0; m_done = 0; m_wrap = 0;
    end else begin
      m_done = 0;
      m_wrap = 0;
      if (stop) begin
        m_st = 0;
      end else if (start && (m_st == 0 || m_st == 3)) begin
        m_lim = int'(limit); m_ps = int'(prescale);
        m_cont = continuous; m_down = down;
        m_e = 0; m_st = 1; m_count = value_at(0);
      end else if (m_st == 1 || m_st == 2) begin
        if (pause) begin
          m_st = 2;
        end else begin
          m_st = 1;
          idx = (m_e / (m_ps + 1)) % (m_lim + 1);
          term_tick = ((m_e % (m_ps + 1)) == m_ps) && (idx == m_lim);
          if (term_tick && !m_cont) begin
            m_done = 1;
            m_st = 3;
          end else begin
            m_wrap = term_tick;
            m_e++;
            m_count = value_at(m_e);
          end
        end
      end
    end
  endfunction

  task automatic step();
    exp_t x;
    model_edge();
    x.count = 4'(m_count);
    x.busy  = (m_st == 1 || m_st == 2);
    x.done  = m_done;
    x.wrap  = m_wrap;
    x.state = 2'(m_st);
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; pause = 0;
  endtask

  task automatic begin_seq(input int lim, input int ps, input bit cont, input bit dn);
    limit = 4'(lim); prescale = 4'(ps); continuous = cont; down = dn;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL timeout: driver did not finish within the wait bound");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({count, busy, done, wrap, state} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got count=%0d busy=%b done=%b wrap=%b state=%0d, expected count=%0d busy=%b done=%b wrap=%b state=%0d",
                   $time, count, busy, done, wrap, state,
                   e.count, e.busy, e.done, e.wrap, e.state);
        end
      end
    end
  end

  initial begin : driver
    idle_inputs();
    limit = 4'd7; prescale = 4'd2; continuous = 1; down = 0;
    rst = 1;
    steps(2);
    rst = 0;

    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        wrap !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset state t=%0t: count=%0d busy=%b done=%b wrap=%b state=%0d",
               $time, count, busy, done, wrap, state);
    end

    begin_seq(3, 0, 0, 0);
    steps(7);

    begin_seq(2, 1, 1, 1);
    steps(14);
    stop = 1; step(); stop = 0;

    begin_seq(5, 3, 0, 0);
    steps(6);
    pause = 1; steps(5); pause = 0;
    steps(20);

    begin_seq(9, 0, 0, 0);
    steps(5);
    stop = 1; pause = 1; step();
    stop = 0; pause = 0;
    steps(2);

    begin_seq(15, 0, 1, 0);
    for (int unsigned i = 0; i < 40; i++) begin
      limit = 4'($urandom_range(0, 15));
      down = 1'($urandom_range(0, 1));
      step();
    end
    stop = 1; step(); stop = 0;

    begin_seq(0, 1, 1, 0);
    steps(6);
    stop = 1; step(); stop = 0;
    begin_seq(0, 0, 0, 1);
    steps(3);

    begin_seq(2, 0, 0, 0);
    steps(2);
    rst = 1; step(); rst = 0;
    steps(2);

    for (int unsigned i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      limit = 4'($urandom_range(0, 15));
      prescale = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 2));
      continuous = 1'($urandom_range(0, 1));
      down = 1'($urandom_range(0, 1));
      step();
    end
    idle_inputs();
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
